// File: rtl/iob_eth_tx_framer_pkg.sv
// Shared constants, FSM encoding and header-byte helper for the TX frame builder.
package iob_eth_tx_framer_pkg;

    localparam logic [7:0] ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0] ETH_SFD         = 8'hD5;
    localparam int         ETH_HDR_END     = 22;
    localparam int         ETH_MIN_PAYLOAD = 46;
    localparam int         ETH_MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_PAY      = 3'd2,
        ST_PAD      = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_ACK = 3'd5,
        ST_DROP     = 3'd6
    } tx_state_e;

    // Byte idx (0..21) of the preamble/SFD/MAC header image; MSB-first fields.
    function automatic logic [7:0] hdr_byte(input logic [4:0]  idx,
                                            input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [15:0] typ);
        logic [7:0] b;
        case (idx)
            5'd0, 5'd1, 5'd2, 5'd3,
            5'd4, 5'd5, 5'd6: b = ETH_PREAMBLE;
            5'd7:  b = ETH_SFD;
            5'd8:  b = dst[47:40];
            5'd9:  b = dst[39:32];
            5'd10: b = dst[31:24];
            5'd11: b = dst[23:16];
            5'd12: b = dst[15:8];
            5'd13: b = dst[7:0];
            5'd14: b = src[47:40];
            5'd15: b = src[39:32];
            5'd16: b = src[31:24];
            5'd17: b = src[23:16];
            5'd18: b = src[15:8];
            5'd19: b = src[7:0];
            5'd20: b = typ[15:8];
            5'd21: b = typ[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/iob_eth_tx_framer_ram.sv
// Simple dual-port RAM: synchronous write, registered read, no reset on contents.
module iob_eth_tx_ram #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;

    // Write port and registered read port, both every cycle on clk.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/iob_eth_tx_framer.sv
// Builds preamble/SFD/MAC header/payload/padding image in the TX buffer and
// hands it to the MII transmitter with a one-cycle send and a payload count.
// Payload handshake: a byte transfers on a TX_CLK edge where s_valid and s_ready
// are both 1; s_ready depends only on FSM state, never on s_valid.
module iob_eth_tx_framer
    import iob_eth_tx_framer_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h0002_0304_0506,
    parameter int          BUF_AW  = 11
) (
    input  logic              TX_CLK,
    input  logic              tx_rst,
    input  logic [47:0]       dst_mac,
    input  logic [15:0]       eth_type,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              tx_ready,
    output logic              send,
    output logic [BUF_AW-1:0] nbytes,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              err_oversize,
    output logic [2:0]        dbg_state
);

    localparam logic [BUF_AW-1:0] ONE_A      = BUF_AW'(1);
    localparam logic [BUF_AW-1:0] HDR_LAST_A = BUF_AW'(ETH_HDR_END - 1);
    localparam logic [BUF_AW-1:0] HDR_END_A  = BUF_AW'(ETH_HDR_END);
    localparam logic [BUF_AW-1:0] MIN_A      = BUF_AW'(ETH_MIN_PAYLOAD);
    localparam logic [BUF_AW-1:0] MAX_A      = BUF_AW'(ETH_MAX_PAYLOAD);

    tx_state_e         state_q, state_d;
    logic [BUF_AW-1:0] cnt_q, cnt_d;
    logic [47:0]       dst_q, dst_d;
    logic [15:0]       typ_q, typ_d;
    logic [BUF_AW-1:0] nbytes_q, nbytes_d;

    logic              we;
    logic [BUF_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [BUF_AW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + ONE_A;

    // State register and frame bookkeeping; reset abandons any partial frame.
    always_ff @(posedge TX_CLK or posedge tx_rst) begin
        if (tx_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dst_q    <= '0;
            typ_q    <= '0;
            nbytes_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            typ_q    <= typ_d;
            nbytes_q <= nbytes_d;
        end
    end

    // Next-state, buffer write port and handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dst_d        = dst_q;
        typ_d        = typ_q;
        nbytes_d     = nbytes_q;
        we           = 1'b0;
        wr_addr      = '0;
        wr_data      = 8'h00;
        s_ready      = 1'b0;
        send         = 1'b0;
        err_oversize = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The start byte is left on the stream; it is taken in PAY.
                if (tx_ready && s_valid) begin
                    dst_d   = dst_mac;
                    typ_d   = eth_type;
                    cnt_d   = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                we      = 1'b1;
                wr_addr = cnt_q;
                wr_data = hdr_byte(cnt_q[4:0], dst_q, SRC_MAC, typ_q);
                if (cnt_q == HDR_LAST_A) begin
                    cnt_d   = '0;
                    state_d = ST_PAY;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PAY: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (cnt_q == MAX_A) begin
                        // Buffer full: the 1501st byte is never written.
                        if (s_last) begin
                            err_oversize = 1'b1;
                            nbytes_d     = MAX_A;
                            state_d      = ST_SEND;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        we      = 1'b1;
                        wr_addr = HDR_END_A + cnt_q;
                        wr_data = s_data;
                        cnt_d   = cnt_inc;
                        if (s_last) begin
                            if (cnt_inc < MIN_A) begin
                                state_d = ST_PAD;
                            end else begin
                                nbytes_d = cnt_inc;
                                state_d  = ST_SEND;
                            end
                        end
                    end
                end
            end
            ST_PAD: begin
                we      = 1'b1;
                wr_addr = HDR_END_A + cnt_q;
                wr_data = 8'h00;
                cnt_d   = cnt_inc;
                if (cnt_inc == MIN_A) begin
                    nbytes_d = MIN_A;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                send    = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // The transmitter drops tx_ready once it has picked up send.
                if (!tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    err_oversize = 1'b1;
                    nbytes_d     = MAX_A;
                    state_d      = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign nbytes    = nbytes_q;
    assign dbg_state = state_q;

    iob_eth_tx_ram #(
        .AW (BUF_AW),
        .DW (8)
    ) u_ram (
        .clk     (TX_CLK),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// Directed bench for iob_eth_tx_framer: drives payload streams, models the
// transmitter handshake and reads the frame image back through the read port.
module tb_iob_eth_tx_framer;
    import iob_eth_tx_framer_pkg::*;

    localparam logic [47:0] SRC = 48'h0002_0304_0506;
    localparam int          BUDGET = 2000;

    logic        TX_CLK = 1'b0;
    logic        tx_rst;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        tx_ready;
    logic        send;
    logic [10:0] nbytes;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        err_oversize;
    logic [2:0]  dbg_state;

    logic [7:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // monitor counters (written only by the monitor)
    int ncyc      = 0;
    int send_cnt  = 0;
    int err_cnt   = 0;
    int pad_cyc   = 0;
    int start_cyc = 0;
    int rdy_lat   = 0;
    logic rdy_prev = 1'b0;

    iob_eth_tx_framer dut (
        .TX_CLK       (TX_CLK),
        .tx_rst       (tx_rst),
        .dst_mac      (dst_mac),
        .eth_type     (eth_type),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .tx_ready     (tx_ready),
        .send         (send),
        .nbytes       (nbytes),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .err_oversize (err_oversize),
        .dbg_state    (dbg_state)
    );

    // clock
    always #5 TX_CLK = ~TX_CLK;

    // monitor: sampled 1 time unit after each falling edge
    always @(negedge TX_CLK) begin
        #1;
        ncyc++;
        if (send) send_cnt++;
        if (err_oversize) err_cnt++;
        if (dbg_state == ST_PAD) pad_cyc++;
        if (dbg_state == ST_IDLE && tx_ready && s_valid && !tx_rst) start_cyc = ncyc;
        if (s_ready && !rdy_prev) rdy_lat = ncyc - start_cyc;
        rdy_prev = s_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one payload byte; called and returns at a falling edge
    task automatic put_byte(input logic [7:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < BUDGET) begin
            @(negedge TX_CLK);
            t++;
        end
        check("accept_timeout", 32'(t < BUDGET), 32'd1);
        @(negedge TX_CLK);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // registered read: address at a falling edge, data one cycle later
    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        rd_addr = a;
        @(negedge TX_CLK);
        d = rd_data;
    endtask

    task automatic run_frame(input logic [47:0] dst, input logic [15:0] typ, input int n,
                             input int max_gap, input int ack_delay);
        int sc0, er0, pad0, t, nexp, npay, npad;
        logic [7:0] d;
        logic [7:0] hdr [22];
        sc0  = send_cnt;
        er0  = err_cnt;
        pad0 = pad_cyc;
        nexp = (n < 46) ? 46 : ((n > 1500) ? 1500 : n);
        npay = (n > 1500) ? 1500 : n;
        npad = (n < 46) ? 46 - n : 0;
        dst_mac  = dst;
        eth_type = typ;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i < 1500) exp_q.push_back(d);
            put_byte(d, i == n - 1);
            if (max_gap > 0 && i < n - 1) repeat ($urandom_range(0, max_gap)) @(negedge TX_CLK);
        end
        t = 0;
        while (!send && t < 200) begin
            @(negedge TX_CLK);
            t++;
        end
        check("send_timeout", 32'(t < 200), 32'd1);
        check("nbytes_at_send", 32'(nbytes), 32'(nexp));
        repeat (ack_delay) @(negedge TX_CLK);
        if (ack_delay >= 5) begin
            check("wait_ack_hold", 32'(dbg_state), 32'(ST_WAIT_ACK));
            check("busy_wait_ack", 32'(busy), 32'd1);
        end
        tx_ready = 1'b0;
        repeat (3) @(negedge TX_CLK);
        check("idle_after_ack", 32'(dbg_state), 32'(ST_IDLE));
        check("busy_idle", 32'(busy), 32'd0);
        check("send_pulses", 32'(send_cnt - sc0), 32'd1);
        check("err_pulses", 32'(err_cnt - er0), 32'((n > 1500) ? 1 : 0));
        check("pad_cycles", 32'(pad_cyc - pad0), 32'(npad));
        check("nbytes_held", 32'(nbytes), 32'(nexp));
        for (int i = 0; i < 7; i++) hdr[i] = 8'h55;
        hdr[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            hdr[8 + i]  = dst[8 * (5 - i) +: 8];
            hdr[14 + i] = SRC[8 * (5 - i) +: 8];
        end
        hdr[20] = typ[15:8];
        hdr[21] = typ[7:0];
        for (int i = 0; i < 22; i++) begin
            rd(11'(i), d);
            check("hdr_byte", 32'(d), 32'(hdr[i]));
        end
        for (int i = 0; i < npay; i++) begin
            rd(11'(22 + i), d);
            check("payload_byte", 32'(d), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < npad; i++) begin
            rd(11'(22 + n + i), d);
            check("pad_byte", 32'(d), 32'd0);
        end
        tx_ready = 1'b1;
        @(negedge TX_CLK);
    endtask

    initial begin : stim
        int sc0;
        logic [7:0] d;
        logic [7:0] snap [10];

        // reset
        tx_rst   = 1'b1;
        dst_mac  = '0;
        eth_type = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        tx_ready = 1'b1;
        rd_addr  = '0;
        repeat (3) @(negedge TX_CLK);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_nbytes", 32'(nbytes), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_oversize), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tx_rst = 1'b0;
        @(negedge TX_CLK);

        // 60-byte broadcast IPv4 frame
        run_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 60, 0, 3);
        check("s_ready_latency", 32'(rdy_lat), 32'd23);

        // transmitter busy: no start, no s_ready
        tx_ready = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'hA5;
        repeat (10) @(negedge TX_CLK);
        check("blocked_state", 32'(dbg_state), 32'(ST_IDLE));
        check("blocked_s_ready", 32'(s_ready), 32'd0);
        check("blocked_busy", 32'(busy), 32'd0);
        tx_ready = 1'b1;

        // 10-byte frame, padded; held tx_ready after send
        run_frame(48'h1122_3344_5566, 16'h88B5, 10, 0, 5);

        // 100-byte frame with random stalls
        run_frame(48'hA0B1_C2D3_E4F5, 16'h0806, 100, 3, 3);

        // oversize: 1510-byte stream; addresses beyond 1521 must be untouched
        for (int i = 0; i < 10; i++) rd(11'(1522 + i), snap[i]);
        run_frame(48'h0A0B_0C0D_0E0F, 16'h86DD, 1510, 0, 3);
        for (int i = 0; i < 10; i++) begin
            rd(11'(1522 + i), d);
            check("drop_untouched", 32'(d), 32'(snap[i]));
        end

        // reset after 30 payload bytes
        sc0 = send_cnt;
        dst_mac  = 48'hDEAD_BEEF_0001;
        eth_type = 16'h1234;
        for (int i = 0; i < 30; i++) put_byte(8'($urandom_range(0, 255)), 1'b0);
        tx_rst = 1'b1;
        @(negedge TX_CLK);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_nbytes", 32'(nbytes), 32'd0);
        @(negedge TX_CLK);
        tx_rst = 1'b0;
        repeat (60) @(negedge TX_CLK);
        check("midrst_no_send", 32'(send_cnt - sc0), 32'd0);

        run_frame(48'h0200_0000_0042, 16'h0800, 50, 1, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
